or_sticky_capture: RTL and testbench
====================================

# or_sticky_capture

Parametrised sticky event-capture register built around a switch-level OR reduction. CHANNELS input vectors of WIDTH bits are OR-reduced per bit by a transistor-level OR network. Hits are accumulated into a sticky register and counted. A four-phase read handshake snapshots the register, clears it and re-arms it. It sits behind the switch-level gate library as the first stateful consumer of the OR cell.

## Interface
Parameters:
- WIDTH, 4: bits per channel and width of the sticky register.
- CHANNELS, 2: number of input vectors OR-ed together, ≥1.
- CNT_W, 4: width of the saturating hit counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  accumulate enable; when low, or_vec is ignored by state.
- in  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- or_vec  output  WIDTH  combinational per-bit OR across channels (no register).
- rd_req  input  1  four-phase read request (level).
- rd_ack  output  1  four-phase read acknowledge (registered).
- rd_data  output  WIDTH  snapshot of sticky register, valid while rd_ack=1.
- rd_cnt  output  CNT_W  snapshot of hit counter, valid while rd_ack=1.

## Operation
- hit = en & (|or_vec).
- Handshake FSM, two states:
  - IDLE: rd_ack=0.
  - ACK: rd_ack=1.
  - IDLE→ACK when rd_req=1; this edge is the capture edge.
  - ACK→IDLE when rd_req=0.
  - A new read requires rd_req to drop and rise again.
- Capture edge:
  - rd_data<=sticky; rd_cnt<=cnt.
  - sticky<=(en ? or_vec : 0), so events arriving in the capture cycle go into the next window and are not lost.
  - cnt<=hit ? 1 : 0.
- Any other edge, not reset:
  - sticky<=sticky | (en ? or_vec : 0).
  - cnt<=cnt+1 if hit and cnt≠2^CNT_W−1; otherwise cnt holds (saturating, never wraps).
- rd_data and rd_cnt hold between captures, including while in IDLE.
- rst=1 at an edge has priority over everything:
  - state=IDLE, rd_ack=0, sticky=0, cnt=0, rd_data=0, rd_cnt=0.
  - Applies mid-handshake: ack drops the next edge even if rd_req is still 1, and no capture occurs on that edge.
  - After rst releases with rd_req still high, the first non-reset edge is a capture edge.

## Timing
- or_vec: zero-cycle combinational; follows in through the switch network.
- Capture latency: rd_req sampled high in IDLE at edge N → rd_ack=1 and rd_data/rd_cnt valid after edge N.
- Release: rd_req sampled low at edge M → rd_ack=0 after edge M.
- Minimum handshake period: 2 cycles. rd_req high/low for one cycle each gives ack high for exactly one cycle.
- Reset values of all outputs: rd_ack=0, rd_data=0, rd_cnt=0. or_vec reflects in regardless of reset.

## Structure
- Package or_sticky_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_ACK=1'b1;
  - the channel-slice index helper constant convention.
- One sub-module, or_tree_sw(WIDTH, CHANNELS):
  - per bit, a CHANNELS-high series pmos pull-up stack and CHANNELS parallel nmos pull-downs form a NOR;
  - a pmos/nmos inverter stage follows, with supply1/supply0 rails;
  - generate loops over bits and channels.
- The top level instantiates or_tree_sw and holds the FSM, the sticky register and the counter as synchronous behavioural logic.

## Test plan
- Reset: hold rst 3 cycles with in=all-ones, en=1, rd_req=1 → rd_ack=0, rd_data=0, rd_cnt=0. The first edge after release captures rd_data=0 and rd_cnt=0.
- Accumulate and read (WIDTH=4, CHANNELS=2):
  - inject ch0=0001, then ch1=0100, then 0 with en=1;
  - pulse rd_req → rd_data=0101, rd_cnt=2, rd_ack high one edge after the request;
  - the next read returns 0000, cnt 0.
- Capture-cycle collision: or_vec=1000 with en=1 on the capture edge → the current read excludes bit 3, and the following read returns 1000 with rd_cnt=1.
- Saturation: CNT_W=4, 20 consecutive hit cycles → rd_cnt=15. With en=0 for 5 cycles of in=1111, a read returns sticky unchanged and the count does not advance.
- Handshake rules:
  - rd_req held high 6 cycles → exactly one capture, rd_ack high until 1 edge after rd_req falls;
  - rst asserted mid-ACK → rd_ack=0 next edge, and rd_data=0 and rd_cnt=0.
- or_tree_sw exhaustive check: CHANNELS=3, WIDTH=1, all 8 input combinations → or_vec equals the logical OR, with no x or z values on the output.

Source files
------------

// File: rtl/or_sticky_pkg.sv
// Shared types and helpers for the sticky OR capture block.
package or_sticky_pkg;

  // Read handshake states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_e;

  // LSB index of channel ch inside a flattened CHANNELS*WIDTH input bus
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/or_tree_sw.sv
// Per-bit OR across channels built from switch-level NOR + inverter stages.
module or_tree_sw
  import or_sticky_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2
) (
  input  logic [CHANNELS*WIDTH-1:0] in_i,
  output wire  [WIDTH-1:0]          or_o
);

  supply1 vdd;
  supply0 gnd;

  // One NOR (series pull-up stack, parallel pull-downs) plus inverter per bit
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    // stk[c] is the node below the c-th pull-up; the last one is the NOR output
    wire [CHANNELS-1:0] stk;
    wire                y;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      if (c == 0) begin : g_top
        pmos p_up (stk[0], vdd, in_i[ch_lsb(c, WIDTH) + b]);
      end else begin : g_mid
        pmos p_up (stk[c], stk[c-1], in_i[ch_lsb(c, WIDTH) + b]);
      end
      nmos n_dn (stk[CHANNELS-1], gnd, in_i[ch_lsb(c, WIDTH) + b]);
    end

    // Output inverter turns the NOR into an OR
    pmos p_inv (y, vdd, stk[CHANNELS-1]);
    nmos n_inv (y, gnd, stk[CHANNELS-1]);

    assign or_o[b] = y;
  end

endmodule

// File: rtl/or_sticky_capture.sv
// Sticky event capture: OR-reduce channels, accumulate hits, snapshot on a four-phase read.
module or_sticky_capture
  import or_sticky_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [WIDTH-1:0]          or_vec,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CNT_W-1:0]          rd_cnt
);

  wire [WIDTH-1:0] or_w;

  rd_state_e        state_q;
  logic             rd_ack_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] add_vec;
  logic             hit;
  logic             capture;

  or_tree_sw #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) u_or_tree (
    .in_i(in),
    .or_o(or_w)
  );

  assign or_vec  = or_w;
  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign rd_cnt  = rd_cnt_q;

  // Next sticky/count: a capture opens a fresh window seeded with this cycle's events
  always_comb begin
    add_vec  = en ? or_vec : '0;
    hit      = en & (|or_vec);
    capture  = (state_q == ST_IDLE) && rd_req;
    sticky_d = sticky_q | add_vec;
    cnt_d    = cnt_q;
    if (capture) begin
      sticky_d = add_vec;
      cnt_d    = hit ? CNT_W'(1) : '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Handshake FSM, snapshot registers and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_cnt_q  <= '0;
      sticky_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_req) begin
            state_q   <= ST_ACK;
            rd_ack_q  <= 1'b1;
            rd_data_q <= sticky_q;
            rd_cnt_q  <= cnt_q;
          end
        end
        ST_ACK: begin
          if (!rd_req) begin
            state_q  <= ST_IDLE;
            rd_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          rd_ack_q <= 1'b0;
        end
      endcase
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_or_sticky_capture.sv
// Randomized + directed bench for or_sticky_capture against a window-level reference model.
module tb_or_sticky_capture;

  localparam int unsigned W   = 4;
  localparam int unsigned CH  = 2;
  localparam int unsigned CW  = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, rd_req;
  logic [CH*W-1:0]   in;
  logic [W-1:0]      or_vec;
  logic              rd_ack;
  logic [W-1:0]      rd_data;
  logic [CW-1:0]     rd_cnt;

  // Small instance for the exhaustive 3-channel, 1-bit OR check
  logic [2:0]        in3;
  logic [0:0]        or3;
  logic              ack3;
  logic [0:0]        data3;
  logic [CW-1:0]     cnt3;

  int tests = 0;
  int fails = 0;

  or_sticky_capture #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .or_vec(or_vec),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_cnt(rd_cnt)
  );

  or_sticky_capture #(.WIDTH(1), .CHANNELS(3), .CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .en(en), .in(in3), .or_vec(or3),
    .rd_req(rd_req), .rd_ack(ack3), .rd_data(data3), .rd_cnt(cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] or_chan(input logic [CH*W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r = r | v[c*W +: W];
    return r;
  endfunction

  // Reference model: a read window collects events and a plain hit tally
  bit           m_valid = 0;
  bit           m_acked = 0;
  logic [W-1:0] m_window = '0;
  int           m_hits = 0;
  logic [W-1:0] m_data = '0;
  int           m_cnt = 0;
  logic [W-1:0] s_or;
  bit           s_hit;

  always @(posedge clk) begin
    s_or  = or_chan(in);
    s_hit = en && (s_or != '0);
    if (rst) begin
      m_valid  = 1;
      m_acked  = 0;
      m_window = '0;
      m_hits   = 0;
      m_data   = '0;
      m_cnt    = 0;
    end else if (m_valid) begin
      if (!m_acked && rd_req) begin
        m_data   = m_window;
        m_cnt    = (m_hits > MAXC) ? MAXC : m_hits;
        m_acked  = 1;
        m_window = en ? s_or : '0;
        m_hits   = s_hit ? 1 : 0;
      end else begin
        if (!rd_req) m_acked = 0;
        if (en) m_window = m_window | s_or;
        if (s_hit) m_hits = m_hits + 1;
      end
    end
    #1;
    chk("or_vec", 32'(or_vec), 32'(or_chan(in)));
    if (m_valid) begin
      chk("model_ack", 32'(rd_ack), 32'(m_acked));
      chk("model_data", 32'(rd_data), 32'(m_data));
      chk("model_cnt", 32'(rd_cnt), 32'(m_cnt));
    end
  end

  task automatic read_once(output logic [W-1:0] d, output logic [CW-1:0] c);
    rd_req = 1'b1;
    @(negedge clk);
    chk("read_ack_rise", 32'(rd_ack), 32'd1);
    d = rd_data;
    c = rd_cnt;
    rd_req = 1'b0;
    @(negedge clk);
    chk("read_ack_fall", 32'(rd_ack), 32'd0);
  endtask

  logic [W-1:0]  d;
  logic [CW-1:0] c;

  initial begin
    rst = 1'b1; en = 1'b1; in = '1; rd_req = 1'b1; in3 = '0;

    // Reset with everything asserted
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_cnt", 32'(rd_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cap_ack", 32'(rd_ack), 32'd1);
    chk("post_rst_cap_data", 32'(rd_data), 32'd0);
    chk("post_rst_cap_cnt", 32'(rd_cnt), 32'd0);
    rd_req = 1'b0; in = '0;
    @(negedge clk);
    read_once(d, c);
    chk("flush_data", 32'(d), 32'hF);
    chk("flush_cnt", 32'(c), 32'd1);

    // Accumulate ch0=0001 then ch1=0100
    in = 8'h01; @(negedge clk);
    in = 8'h40; @(negedge clk);
    in = 8'h00; @(negedge clk);
    read_once(d, c);
    chk("acc_data", 32'(d), 32'h5);
    chk("acc_cnt", 32'(c), 32'd2);
    read_once(d, c);
    chk("empty_data", 32'(d), 32'h0);
    chk("empty_cnt", 32'(c), 32'd0);

    // Event on the capture edge goes to the next window
    in = 8'h08; rd_req = 1'b1;
    @(negedge clk);
    chk("coll_data", 32'(rd_data), 32'h0);
    chk("coll_cnt", 32'(rd_cnt), 32'd0);
    in = 8'h00; rd_req = 1'b0;
    @(negedge clk);
    read_once(d, c);
    chk("coll_next_data", 32'(d), 32'h8);
    chk("coll_next_cnt", 32'(c), 32'd1);

    // Saturation after 20 hit cycles
    for (int i = 0; i < 20; i++) begin
      in = 8'($urandom_range(1, 255));
      @(negedge clk);
    end
    in = '0;
    read_once(d, c);
    chk("sat_cnt", 32'(c), 32'd15);

    // en=0 blocks both sticky and count
    in = 8'h20; @(negedge clk);
    en = 1'b0; in = 8'hFF;
    repeat (5) @(negedge clk);
    en = 1'b1; in = '0;
    read_once(d, c);
    chk("en_off_data", 32'(d), 32'h2);
    chk("en_off_cnt", 32'(c), 32'd1);

    // rd_req held high 6 cycles: one capture only
    in = 8'h10; @(negedge clk);
    rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in = (i == 2) ? 8'h04 : 8'h00;
      @(negedge clk);
      chk("hold_ack", 32'(rd_ack), 32'd1);
      chk("hold_data", 32'(rd_data), 32'h1);
    end
    rd_req = 1'b0; in = '0;
    @(negedge clk);
    chk("hold_release", 32'(rd_ack), 32'd0);
    read_once(d, c);
    chk("hold_next_data", 32'(d), 32'h4);
    chk("hold_next_cnt", 32'(c), 32'd1);

    // Reset in the middle of an ACK
    in = 8'h11; @(negedge clk);
    in = 8'h00; rd_req = 1'b1; @(negedge clk);
    chk("mid_ack", 32'(rd_ack), 32'd1);
    chk("mid_data", 32'(rd_data), 32'h1);
    chk("mid_cnt", 32'(rd_cnt), 32'd1);
    rst = 1'b1; @(negedge clk);
    chk("mid_rst_ack", 32'(rd_ack), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'h0);
    chk("mid_rst_cnt", 32'(rd_cnt), 32'd0);
    rst = 1'b0; @(negedge clk);
    chk("mid_recap_ack", 32'(rd_ack), 32'd1);
    chk("mid_recap_data", 32'(rd_data), 32'h0);
    rd_req = 1'b0; @(negedge clk);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      in  = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) == 0) rd_req = ~rd_req;
      @(negedge clk);
    end
    rst = 1'b0; rd_req = 1'b0; en = 1'b1; in = '0;
    @(negedge clk);

    // Exhaustive 3-input OR through the switch network
    for (int v = 0; v < 8; v++) begin
      in3 = 3'(v);
      #1;
      chk("or3_exhaustive", 32'(or3), 32'(|in3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
